// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 16x oversampling, start/stop bit
//               validation, a small receive FIFO and a register-bus front end
//               (divisor, RX data, control/status).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter logic [7:0] PERIOD = 8'h1A,
  parameter int         DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wren,
  input  logic       i_rden,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  input  logic       i_rxin,
  output logic       o_rxready
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  localparam logic [2:0] c_ADDR_DIV  = 3'b000;
  localparam logic [2:0] c_ADDR_DATA = 3'b001;
  localparam logic [2:0] c_ADDR_CTRL = 3'b011;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic               r_rx_s1, r_rx_s2;
  logic [7:0]         r_div;
  logic [7:0]         r_tcnt;
  logic [3:0]         r_scnt;
  logic [2:0]         r_bitcnt;
  logic [1:0]         r_state;
  logic [7:0]         r_shift;
  logic [7:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_rxready;
  logic               r_overrun, r_framerr;

  logic               w_rx, w_tick, w_mid, w_end, w_start;
  logic               w_div_wr, w_err_clr;
  logic               w_stop_smp, w_push_req, w_push, w_pop, w_full, w_ovr, w_ferr;
  logic [c_PTR_W:0]   w_count_nxt;
  logic [7:0]         w_status;

  assign w_rx       = r_rx_s2;
  assign w_tick     = (r_tcnt == r_div);
  assign w_mid      = w_tick && (r_scnt == 4'd7);
  assign w_end      = w_tick && (r_scnt == 4'd15);
  assign w_start    = (r_state == c_IDLE) && !w_rx;
  assign w_div_wr   = i_wren && (i_addr == c_ADDR_DIV);
  assign w_err_clr  = i_wren && (i_addr == c_ADDR_CTRL);
  assign w_full     = (r_count == c_FULL_CNT);
  assign w_pop      = i_rden && (i_addr == c_ADDR_DATA) && (r_count != '0);
  assign w_stop_smp = (r_state == c_STOP) && w_end;
  assign w_push_req = w_stop_smp && w_rx;
  assign w_ferr     = w_stop_smp && !w_rx;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovr      = w_push_req && w_full && !w_pop;
  assign w_status   = {3'b000, (r_state != c_IDLE), r_framerr, r_overrun,
                       w_full, (r_count != '0)};
  assign o_rxready  = r_rxready;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rxin;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Divisor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_div <= PERIOD;
    else if (w_div_wr) r_div <= i_din;
  end

  // Oversample tick counter; restarted on divisor writes and on a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_tcnt <= '0;
    else if (w_div_wr || w_start)    r_tcnt <= '0;
    else if (w_tick)                 r_tcnt <= '0;
    else                             r_tcnt <= r_tcnt + 8'd1;
  end

  // Receive FSM with sample counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_scnt   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      if (w_tick) r_scnt <= r_scnt + 4'd1;
      case (r_state)
        c_IDLE: begin
          if (!w_rx) begin
            r_state <= c_START;
            r_scnt  <= '0;
          end
        end
        c_START: begin
          if (w_mid) begin
            if (w_rx) begin
              r_state <= c_IDLE;
            end else begin
              // Re-align the sample counter so DATA samples at bit centres.
              r_state  <= c_DATA;
              r_scnt   <= '0;
              r_bitcnt <= '0;
            end
          end
        end
        c_DATA: begin
          if (w_end) begin
            r_shift[r_bitcnt] <= w_rx;
            if (r_bitcnt == 3'd7) r_state  <= c_STOP;
            else                  r_bitcnt <= r_bitcnt + 3'd1;
          end
        end
        default: begin
          if (w_end) r_state <= c_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because emptiness gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  // Occupancy for the next cycle, used for the count and registered rxready.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, count and rxready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rxready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count   <= w_count_nxt;
      r_rxready <= (w_count_nxt != '0);
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_framerr <= 1'b0;
    end else begin
      if (w_ovr)           r_overrun <= 1'b1;
      else if (w_err_clr)  r_overrun <= 1'b0;
      if (w_ferr)          r_framerr <= 1'b1;
      else if (w_err_clr)  r_framerr <= 1'b0;
    end
  end

  // Combinational read mux; zero whenever no valid read is in progress.
  always_comb begin
    o_dout = 8'h00;
    if (i_rden) begin
      case (i_addr)
        c_ADDR_DIV:  o_dout = r_div;
        c_ADDR_DATA: o_dout = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
        c_ADDR_CTRL: o_dout = w_status;
        default:     o_dout = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Expected RX bytes are queued
//               when frames are sent; a monitor compares every data read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [2:0] addr = 3'b000;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rxin = 1'b1;
  logic       rxready;

  int         checks = 0;
  int         failures = 0;
  int         bitclks = 432;
  logic [7:0] q_exp[$];
  logic [7:0] v;

  uart_rx #(.PERIOD(8'h1A), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wren   (wren),
    .i_rden   (rden),
    .i_addr   (addr),
    .i_din    (din),
    .o_dout   (dout),
    .i_rxin   (rxin),
    .o_rxready(rxready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RX-data read is compared with the queue head.
  always @(negedge clk) begin
    if (rden && addr == 3'b001) begin
      if (q_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rxdata_unexpected: got %h expected no read", dout);
      end else begin
        check("rxdata", dout, q_exp.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] val);
    @(posedge clk); #1;
    rden = 1'b1;
    addr = a;
    @(negedge clk);
    val = dout;
    @(posedge clk); #1;
    rden = 1'b0;
    addr = 3'b000;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [7:0] exp, input string name);
    logic [7:0] rv;
    rd(a, rv);
    check(name, rv, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wren = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk); #1;
    wren = 1'b0;
    addr = 3'b000;
    din  = 8'h00;
  endtask

  // Sends one frame. A zero stop bit is held for 3/4 of a bit so the
  // receiver's break restart sees a false start and goes back to idle.
  task automatic send_frame(input logic [7:0] data, input bit stop, input bit chk_ready);
    int n;
    rxin = 1'b0;
    cyc(bitclks);
    for (int i = 0; i < 8; i++) begin
      rxin = data[i];
      cyc(bitclks);
    end
    if (stop) begin
      rxin = 1'b1;
      if (chk_ready) begin
        n = 0;
        while (n < bitclks && !rxready) begin
          cyc(1);
          n++;
        end
        checks++;
        if (!rxready || n < bitclks / 2 - 6 || n > bitclks / 2 + 8) begin
          failures++;
          $display("FAIL stop_to_rxready: got %0d clk (rxready=%b) expected about %0d clk",
                   n, rxready, bitclks / 2 + 3);
        end
        cyc(bitclks - n);
      end else begin
        cyc(bitclks);
      end
    end else begin
      rxin = 1'b0;
      cyc(bitclks * 3 / 4);
      rxin = 1'b1;
      cyc(bitclks - bitclks * 3 / 4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(3);
    check("rxready_in_reset", {7'd0, rxready}, 8'h00);
    check("dout_idle", dout, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    rd_check(3'b000, 8'h1A, "div_reset");
    rd_check(3'b011, 8'h00, "status_reset");
    rd_check(3'b111, 8'h00, "unmapped_addr");

    // Nominal byte
    q_exp.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    rd(3'b001, v);
    check("rxready_after_pop", {7'd0, rxready}, 8'h00);
    rd_check(3'b011, 8'h00, "status_after_pop");

    // False start glitch
    rxin = 1'b0;
    cyc(50);
    rd_check(3'b011, 8'h10, "busy_in_glitch");
    cyc(48);
    rxin = 1'b1;
    cyc(300);
    rd_check(3'b011, 8'h00, "status_false_start");
    check("rxready_false_start", {7'd0, rxready}, 8'h00);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0);
    cyc(bitclks);
    rd_check(3'b011, 8'h08, "status_framerr");
    check("rxready_framerr", {7'd0, rxready}, 8'h00);
    wr(3'b011, 8'h00);
    rd_check(3'b011, 8'h00, "status_err_cleared");

    // Overrun: five bytes, only the first four survive
    for (int i = 1; i <= 4; i++) q_exp.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    rd_check(3'b011, 8'h07, "status_overrun");
    for (int i = 0; i < 4; i++) rd(3'b001, v);
    q_exp.push_back(8'h00);
    rd(3'b001, v);
    rd_check(3'b011, 8'h04, "status_overrun_drained");
    wr(3'b011, 8'h00);
    rd_check(3'b011, 8'h00, "status_overrun_cleared");

    // Divisor change
    wr(3'b000, 8'h0F);
    bitclks = 256;
    rd_check(3'b000, 8'h0F, "div_written");
    q_exp.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    rd(3'b001, v);

    // Reset mid-frame: leave one byte in the FIFO, then abort a frame at bit 4
    send_frame(8'h77, 1'b1, 1'b0);
    check("rxready_before_reset", {7'd0, rxready}, 8'h01);
    rxin = 1'b0;
    cyc(bitclks);
    for (int i = 0; i < 4; i++) begin
      rxin = i[0];
      cyc(bitclks);
    end
    rxin = 1'b1;
    cyc(bitclks / 2);
    rst_n = 1'b0;
    rxin = 1'b1;
    cyc(2);
    rden = 1'b1;
    addr = 3'b011;
    #1;
    check("status_in_reset", dout, 8'h00);
    addr = 3'b000;
    #1;
    check("div_in_reset", dout, 8'h1A);
    rden = 1'b0;
    check("rxready_flushed", {7'd0, rxready}, 8'h00);
    cyc(3);
    rst_n = 1'b1;
    bitclks = 432;
    cyc(2);
    rd_check(3'b011, 8'h00, "status_after_reset");
    q_exp.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b1);
    rd(3'b001, v);
    check("rxready_final", {7'd0, rxready}, 8'h00);

    cyc(2);
    check("queue_drained", 8'(q_exp.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
